// File: rtl/bnn_slice_sequencer.sv
// Slice-stream sequencer for the BNN image decoder: writes one row per accepted
// slice, clears the decoder between frames and hands finished images to the core.
module bnn_slice_sequencer #(
  parameter int NUM_SLICES = 8,
  parameter int SLICE_W    = 8,
  parameter int SEL_W      = 3,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               abort,
  input  logic               in_valid,
  input  logic [SLICE_W-1:0] in_data,
  output logic               in_ready,
  output logic [SLICE_W-1:0] dec_slice,
  output logic [SEL_W-1:0]   dec_sel,
  output logic               dec_en,
  output logic               dec_rst,
  output logic               img_valid,
  input  logic               img_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   img_count
);

  typedef enum logic [1:0] {CLR, LOAD, SETTLE, FULL} state_t;

  state_t           state, state_n;
  logic [SEL_W-1:0] row, row_n;
  logic             hs, accept, last_row;

  // abort masks both handshakes so neither a row write nor a count can slip through
  assign hs       = in_valid && in_ready && !abort;
  assign accept   = img_valid && img_ready && !abort;
  assign last_row = (row == SEL_W'(NUM_SLICES - 1));

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    row_n   = row;
    unique case (state)
      CLR:    state_n = LOAD;
      LOAD: begin
        if (abort) begin
          state_n = CLR;
          row_n   = '0;
        end else if (hs) begin
          row_n = row + 1'b1;
          if (last_row) state_n = SETTLE;
        end
      end
      SETTLE: state_n = abort ? CLR : FULL;
      FULL:   if (abort || accept) state_n = CLR;
      default: begin
        state_n = CLR;
        row_n   = '0;
      end
    endcase
  end

  // NOTE: state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLR;
      row       <= '0;
      in_ready  <= 1'b0;
      dec_slice <= '0;
      dec_sel   <= '0;
      dec_en    <= 1'b0;
      dec_rst   <= 1'b1;
      img_valid <= 1'b0;
      busy      <= 1'b1;
      img_count <= '0;
    end else begin
      state    <= state_n;
      row      <= row_n;
      in_ready <= (state_n == LOAD);
      dec_rst  <= (state_n == CLR);
      dec_en   <= hs;
      busy     <= !((state_n == LOAD) && (row_n == '0));
      if (hs) begin
        dec_slice <= in_data;
        dec_sel   <= row;
      end
      // img_valid trails entry into FULL by a cycle, giving the decoder a settled image
      img_valid <= (state == FULL) && (state_n == FULL);
      if (accept) img_count <= img_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_bnn_slice_sequencer.sv
// Scoreboard bench for bnn_slice_sequencer: expected row writes are queued as
// slices are accepted and matched against dec_en pulses.
module tb_bnn_slice_sequencer;

  localparam int NUM_SLICES = 8;
  localparam int SLICE_W    = 8;
  localparam int SEL_W      = 3;
  // narrow counter so the wrap boundary is reachable in a short run
  localparam int CNT_W      = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               abort;
  logic               in_valid;
  logic [SLICE_W-1:0] in_data;
  logic               in_ready;
  logic [SLICE_W-1:0] dec_slice;
  logic [SEL_W-1:0]   dec_sel;
  logic               dec_en;
  logic               dec_rst;
  logic               img_valid;
  logic               img_ready;
  logic               busy;
  logic [CNT_W-1:0]   img_count;

  bnn_slice_sequencer #(
    .NUM_SLICES(NUM_SLICES), .SLICE_W(SLICE_W), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dec_slice(dec_slice), .dec_sel(dec_sel), .dec_en(dec_en), .dec_rst(dec_rst),
    .img_valid(img_valid), .img_ready(img_ready),
    .busy(busy), .img_count(img_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [SEL_W+SLICE_W-1:0] sb[$];
  logic [SEL_W-1:0]         exp_row   = '0;
  logic [CNT_W-1:0]         exp_count = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // every decoder write must match the oldest accepted slice
  always @(negedge clk) begin
    if (dec_en) begin
      if (sb.size() == 0) begin
        check("dec_en_spurious", 32'(dec_en), 32'(0));
      end else begin
        logic [SEL_W+SLICE_W-1:0] e;
        e = sb.pop_front();
        check("dec_sel", 32'(dec_sel), 32'(e[SEL_W+SLICE_W-1:SLICE_W]));
        check("dec_slice", 32'(dec_slice), 32'(e[SLICE_W-1:0]));
      end
    end
  end

  task automatic send_slice(input logic [SLICE_W-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(n), 32'(0));
    sb.push_back({exp_row, d});
    exp_row = exp_row + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_img();
    int n;
    n = 0;
    @(negedge clk);
    while (!img_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("img_timeout", 32'(n), 32'(0));
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("load_timeout", 32'(n), 32'(0));
  endtask

  task automatic consume_image();
    wait_img();
    img_ready = 1'b1;
    @(posedge clk);
    #1;
    img_ready = 1'b0;
    exp_count = exp_count + 1'b1;
    @(negedge clk);
    check("img_count", 32'(img_count), 32'(exp_count));
  endtask

  task automatic run_image(input logic [SLICE_W-1:0] base);
    for (int i = 0; i < NUM_SLICES; i++) send_slice(base + SLICE_W'(i));
    in_valid = 1'b0;
    consume_image();
  endtask

  initial begin
    int n, bad, seen;
    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = '0; img_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_dec_rst", 32'(dec_rst), 32'(1));
    check("rst_dec_en", 32'(dec_en), 32'(0));
    check("rst_img_valid", 32'(img_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(1));
    check("rst_img_count", 32'(img_count), 32'(0));
    check("rst_dec_sel", 32'(dec_sel), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // back-to-back frame 0x11..0x88 and last-slice to img_valid latency
    wait_ready();
    check("idle_busy", 32'(busy), 32'(0));
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_SLICES; i++) send_slice(SLICE_W'(8'h11 * (i + 1)));
    in_valid = 1'b0;
    n = 0; bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (in_ready) bad++;
    end while (!img_valid && n < 10);
    check("img_latency", 32'(n), 32'(3));
    check("ready_low_after_frame", 32'(bad), 32'(0));

    // stalled consumer with in_valid held high
    in_valid = 1'b1; in_data = 8'h5A; bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (img_valid !== 1'b1 || dec_en || in_ready) bad++;
    end
    check("stall_hold", 32'(bad), 32'(0));
    img_ready = 1'b1;
    @(posedge clk);
    #1;
    img_ready = 1'b0; in_valid = 1'b0;
    exp_count = exp_count + 1'b1;
    @(negedge clk);
    check("accept_dec_rst", 32'(dec_rst), 32'(1));
    check("accept_in_ready", 32'(in_ready), 32'(0));
    check("accept_img_valid", 32'(img_valid), 32'(0));
    check("accept_count", 32'(img_count), 32'(exp_count));
    @(negedge clk);
    check("clr_pulse_width", 32'(dec_rst), 32'(0));
    check("ready_after_2", 32'(in_ready), 32'(1));

    // gapped stream of 0xFF
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_SLICES; i++) begin
      send_slice(8'hFF);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    wait_img();
    check("gap_final_sel", 32'(dec_sel), 32'(NUM_SLICES - 1));
    check("gap_final_slice", 32'(dec_slice), 32'(8'hFF));
    img_ready = 1'b1;
    @(posedge clk);
    #1;
    img_ready = 1'b0;
    exp_count = exp_count + 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (img_valid) seen++;
    end
    check("single_img", 32'(seen), 32'(0));

    // abort after 5 slices, with a slice offered in the abort cycle
    wait_ready();
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send_slice(SLICE_W'(8'h31 + i));
    in_valid = 1'b1; in_data = 8'hEE; abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0; in_valid = 1'b0;
    exp_row = '0;
    @(negedge clk);
    check("abort_dec_rst", 32'(dec_rst), 32'(1));
    check("abort_in_ready", 32'(in_ready), 32'(0));
    check("abort_count", 32'(img_count), 32'(exp_count));
    check("abort_busy", 32'(busy), 32'(1));
    run_image(8'h41);

    // abort coinciding with img_ready
    for (int i = 0; i < NUM_SLICES; i++) send_slice(SLICE_W'(8'h51 + i));
    in_valid = 1'b0;
    wait_img();
    img_ready = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1;
    img_ready = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_accept_count", 32'(img_count), 32'(exp_count));
    check("abort_accept_dec_rst", 32'(dec_rst), 32'(1));
    check("abort_accept_img_valid", 32'(img_valid), 32'(0));

    // abort held: CLR and LOAD alternate
    wait_ready();
    abort = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_hold_dec_rst", 32'(dec_rst), 32'((k % 2) == 0));
      check("abort_hold_in_ready", 32'(in_ready), 32'((k % 2) == 1));
    end
    abort = 1'b0;

    // counter wrap
    wait_ready();
    @(posedge clk);
    #1;
    while (exp_count != '1) run_image(8'h60);
    run_image(8'h70);
    check("count_wrap", 32'(img_count), 32'(0));

    // async reset mid-LOAD
    wait_ready();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send_slice(SLICE_W'(8'hA0 + i));
    #3;
    rst = 1'b1;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'(0));
    check("arst_dec_rst", 32'(dec_rst), 32'(1));
    check("arst_dec_en", 32'(dec_en), 32'(0));
    check("arst_dec_sel", 32'(dec_sel), 32'(0));
    check("arst_dec_slice", 32'(dec_slice), 32'(0));
    check("arst_busy", 32'(busy), 32'(1));
    check("arst_img_count", 32'(img_count), 32'(0));
    sb.delete();
    exp_row = '0; exp_count = '0; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_ready();
    @(posedge clk);
    #1;
    run_image(8'hC1);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
